pixel_frame_loader: RTL and testbench



---
 rtl/network_pkg.sv | 33 +++
 rtl/pixel_bank.sv | 28 ++
 rtl/pixel_frame_loader.sv | 198 +++++++++++++++++++
 tb/tb_pixel_frame_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_pkg.sv
// Shared constants and types for the spike network front end.
package network_pkg;

  localparam int INPUT_SIZE      = 784;
  localparam int PIXEL_WIDTH     = 8;
  localparam int SPIKE_WINDOW    = 16;
  localparam int PRESENT_WINDOWS = 4;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } load_state_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } present_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/pixel_bank.sv
// One frame bank: indexed single-pixel write port, full-array parallel read.
// Contents are deliberately not reset; a frame is only ever read after it
// has been completely written.
module pixel_bank
  import network_pkg::*;
#(
  parameter int INPUT_SIZE  = network_pkg::INPUT_SIZE,
  parameter int PIXEL_WIDTH = network_pkg::PIXEL_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   we,
  input  logic [cnt_width(INPUT_SIZE)-1:0]       idx,
  input  logic [PIXEL_WIDTH-1:0]                 wdata,
  output logic [INPUT_SIZE-1:0][PIXEL_WIDTH-1:0] rdata
);

  logic [INPUT_SIZE-1:0][PIXEL_WIDTH-1:0] mem;

  // Store the incoming pixel at its raster index
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem;

endmodule

// File: rtl/pixel_frame_loader.sv
// Ping-pong frame loader: streams one image into the load bank while the
// other bank is presented to the spike encoder for a fixed number of steps.
module pixel_frame_loader
  import network_pkg::*;
#(
  parameter int INPUT_SIZE      = network_pkg::INPUT_SIZE,
  parameter int PIXEL_WIDTH     = network_pkg::PIXEL_WIDTH,
  parameter int SPIKE_WINDOW    = network_pkg::SPIKE_WINDOW,
  parameter int PRESENT_WINDOWS = network_pkg::PRESENT_WINDOWS
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [PIXEL_WIDTH-1:0]                 s_pixel,
  input  logic                                   s_last,
  input  logic                                   step_tick,
  output logic [INPUT_SIZE-1:0][PIXEL_WIDTH-1:0] pixel_value,
  output logic                                   frame_active,
  output logic                                   frame_start,
  output logic                                   frame_done,
  output logic                                   frame_err
);

  localparam int PRESENT_STEPS = PRESENT_WINDOWS * SPIKE_WINDOW;
  localparam int IDX_W         = cnt_width(INPUT_SIZE);
  localparam int CNT_W         = cnt_width(PRESENT_STEPS);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(INPUT_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(PRESENT_STEPS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  load_state_e    load_state, load_next;
  present_state_e present_state, present_next;
  logic             wr_sel, wr_sel_next;
  logic [IDX_W-1:0] wr_idx, wr_idx_next;
  logic [CNT_W-1:0] step_cnt, step_cnt_next;
  logic             start_next, done_next, err_next;

  logic xfer;
  logic end_tick;
  logic swap;
  logic we0, we1;
  logic [INPUT_SIZE-1:0][PIXEL_WIDTH-1:0] bank0_data, bank1_data;

  // A pixel moves only when the registered ready meets upstream valid.
  assign xfer     = s_valid & s_ready;
  // Last counted tick of the current presentation.
  assign end_tick = (present_state == PRESENT) & step_tick & (step_cnt == LAST_STEP);
  // Hand a full load bank to the presenter when it is free or just finishing.
  assign swap     = (load_state == FULL) & ((present_state == IDLE) | end_tick);

  assign we0 = xfer & ~wr_sel;
  assign we1 = xfer &  wr_sel;

  pixel_bank #(
    .INPUT_SIZE (INPUT_SIZE),
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_bank0 (
    .clk  (clk),
    .we   (we0),
    .idx  (wr_idx),
    .wdata(s_pixel),
    .rdata(bank0_data)
  );

  pixel_bank #(
    .INPUT_SIZE (INPUT_SIZE),
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_bank1 (
    .clk  (clk),
    .we   (we1),
    .idx  (wr_idx),
    .wdata(s_pixel),
    .rdata(bank1_data)
  );

  // Next-state logic for the load and present FSMs, counters and pulses
  always_comb begin
    load_next     = load_state;
    present_next  = present_state;
    wr_sel_next   = wr_sel;
    wr_idx_next   = wr_idx;
    step_cnt_next = step_cnt;
    start_next    = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;

    case (load_state)
      LOAD: begin
        if (xfer) begin
          if (s_last && (wr_idx == LAST_IDX)) begin
            load_next   = FULL;
            wr_idx_next = IDX_ZERO;
          end else if (s_last || (wr_idx == LAST_IDX)) begin
            // Malformed frame: drop what was collected and start over.
            err_next    = 1'b1;
            wr_idx_next = IDX_ZERO;
          end else begin
            wr_idx_next = wr_idx + IDX_W'(1);
          end
        end else begin
          wr_idx_next = wr_idx;
        end
      end
      FULL: begin
        if (swap) begin
          load_next   = LOAD;
          wr_idx_next = IDX_ZERO;
          wr_sel_next = ~wr_sel;
        end else begin
          load_next = FULL;
        end
      end
      default: begin
        load_next   = LOAD;
        wr_idx_next = IDX_ZERO;
      end
    endcase

    case (present_state)
      IDLE: begin
        // Ticks are ignored while idle; the counter stays parked at zero.
        if (swap) begin
          present_next  = PRESENT;
          step_cnt_next = CNT_ZERO;
          start_next    = 1'b1;
        end else begin
          step_cnt_next = CNT_ZERO;
        end
      end
      PRESENT: begin
        if (swap) begin
          // Back-to-back: the old frame ends and the new one begins together.
          present_next  = PRESENT;
          step_cnt_next = CNT_ZERO;
          start_next    = 1'b1;
          done_next     = 1'b1;
        end else if (end_tick) begin
          present_next  = IDLE;
          step_cnt_next = CNT_ZERO;
          done_next     = 1'b1;
        end else if (step_tick) begin
          step_cnt_next = step_cnt + CNT_W'(1);
        end else begin
          step_cnt_next = step_cnt;
        end
      end
      default: begin
        present_next  = IDLE;
        step_cnt_next = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_state    <= LOAD;
      present_state <= IDLE;
      wr_sel        <= 1'b0;
      wr_idx        <= IDX_ZERO;
      step_cnt      <= CNT_ZERO;
      s_ready       <= 1'b1;
      frame_active  <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      load_state    <= load_next;
      present_state <= present_next;
      wr_sel        <= wr_sel_next;
      wr_idx        <= wr_idx_next;
      step_cnt      <= step_cnt_next;
      s_ready       <= (load_next == LOAD);
      frame_active  <= (present_next == PRESENT);
      frame_start   <= start_next;
      frame_done    <= done_next;
      frame_err     <= err_next;
    end
  end

  // Present the read bank (the one not being loaded), zeros when idle
  always_comb begin
    pixel_value = {(INPUT_SIZE*PIXEL_WIDTH){1'b0}};
    if (frame_active) begin
      if (wr_sel) begin
        pixel_value = bank0_data;
      end else begin
        pixel_value = bank1_data;
      end
    end else begin
      pixel_value = {(INPUT_SIZE*PIXEL_WIDTH){1'b0}};
    end
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Self-checking bench for pixel_frame_loader with a frame-level reference model.
module tb_pixel_frame_loader;

  localparam int N     = 4;
  localparam int PW    = 8;
  localparam int SW    = 4;
  localparam int PWIN  = 2;
  localparam int STEPS = PWIN * SW;
  localparam int FW    = N * PW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic step_tick = 1'b0;
  logic [PW-1:0] s_pixel = 8'd0;
  logic s_ready, frame_active, frame_start, frame_done, frame_err;
  logic [N-1:0][PW-1:0] pixel_value;

  int checks = 0;
  int errors = 0;
  int tick_period = 0;

  pixel_frame_loader #(
    .INPUT_SIZE(N), .PIXEL_WIDTH(PW), .SPIKE_WINDOW(SW), .PRESENT_WINDOWS(PWIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_pixel(s_pixel), .s_last(s_last), .step_tick(step_tick),
    .pixel_value(pixel_value), .frame_active(frame_active),
    .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [PW-1:0] m_q[$];
  logic [FW-1:0] m_full, m_cur;
  bit m_have_full, m_presenting, m_start, m_done, m_err;
  int m_ticks;

  task automatic model_reset();
    m_q.delete();
    m_have_full = 1'b0; m_presenting = 1'b0; m_ticks = 0;
    m_start = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_full = '0; m_cur = '0;
  endtask

  task automatic model_step();
    bit ready, end_now, swap;
    logic [FW-1:0] f;
    ready   = !m_have_full;
    end_now = m_presenting && step_tick && (m_ticks == STEPS - 1);
    swap    = m_have_full && (!m_presenting || end_now);
    m_start = 1'b0; m_done = 1'b0; m_err = 1'b0;
    if (swap) begin
      m_cur = m_full; m_have_full = 1'b0; m_presenting = 1'b1;
      m_ticks = 0; m_start = 1'b1; m_done = end_now;
    end else if (end_now) begin
      m_presenting = 1'b0; m_ticks = 0; m_done = 1'b1;
    end else if (m_presenting && step_tick) begin
      m_ticks++;
    end
    if (ready && s_valid) begin
      m_q.push_back(s_pixel);
      if (s_last && m_q.size() == N) begin
        f = '0;
        for (int i = 0; i < N; i++) f[i*PW +: PW] = m_q[i];
        m_full = f; m_have_full = 1'b1; m_q.delete();
      end else if (s_last || m_q.size() == N) begin
        m_err = 1'b1; m_q.delete();
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("s_ready", s_ready, !m_have_full);
        chk("frame_active", frame_active, m_presenting);
        chk("frame_start", frame_start, m_start);
        chk("frame_done", frame_done, m_done);
        chk("frame_err", frame_err, m_err);
        chk("pixel_value", pixel_value, m_presenting ? m_cur : '0);
      end
    end
  end

  // Step tick generator: every tick_period cycles, none when zero
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      step_tick = (tick_period > 0) ? ((cyc % tick_period) == 0) : 1'b0;
    end
  end

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [PW-1:0] p, input logic last);
    bit acc;
    int n;
    acc = 1'b0; n = 0;
    s_valid = 1'b1; s_pixel = p; s_last = last;
    while (!acc && n < 200) begin
      acc = s_ready;
      cyc1();
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send4(input logic [PW-1:0] a, b, c, d, input logic last);
    send(a, 1'b0); send(b, 1'b0); send(c, 1'b0); send(d, last);
  endtask

  // which: 0 = wait for frame_done, 1 = wait for presenter idle
  task automatic wait_for(input int which, input string name);
    int n;
    bit hit;
    n = 0;
    hit = (which == 0) ? frame_done : !frame_active;
    while (!hit && n < 300) begin
      cyc1(); n++;
      hit = (which == 0) ? frame_done : !frame_active;
    end
    if (!hit) chk(name, 64'd0, 64'd1);
  endtask

  task automatic count_active(input string name, input int exp);
    int n;
    n = 1;
    cyc1();
    while (frame_active && n < 100) begin n++; cyc1(); end
    chk(name, n, exp);
    chk({name, "_done"}, frame_done, 1'b1);
    chk({name, "_zero"}, pixel_value, 64'd0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_active", frame_active, 1'b0);
    chk("rst_start", frame_start, 1'b0);
    chk("rst_pixels", pixel_value, 64'd0);
    rst_n = 1'b1;
    cyc1();

    // Single frame, tick every cycle (a tick also lands on the swap edge)
    tick_period = 1;
    send4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    chk("s1_ready_low", s_ready, 1'b0);
    chk("s1_start_early", frame_start, 1'b0);
    cyc1();
    chk("s1_start", frame_start, 1'b1);
    chk("s1_pixels", pixel_value, 64'h281E140A);
    count_active("s1_len", STEPS);

    // Back-to-back: A presents while B loads
    tick_period = 3;
    send4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    send4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    chk("s2_ready_low", s_ready, 1'b0);
    chk("s2_a_active", frame_active, 1'b1);
    wait_for(0, "s2_done_timeout");
    chk("s2_start_with_done", frame_start, 1'b1);
    chk("s2_active_kept", frame_active, 1'b1);
    chk("s2_pixels_b", pixel_value, 64'h04030201);
    chk("s2_ready_back", s_ready, 1'b1);
    wait_for(1, "s2_idle_timeout");

    // Early s_last on the third pixel
    tick_period = 1;
    send(8'd5, 1'b0); send(8'd6, 1'b0); send(8'd7, 1'b1);
    chk("s3_err", frame_err, 1'b1);
    chk("s3_ready", s_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc1();
      chk("s3_nothing", frame_active, 1'b0);
    end
    send4(8'd11, 8'd12, 8'd13, 8'd14, 1'b1);
    cyc1();
    chk("s3_start", frame_start, 1'b1);
    chk("s3_pixels", pixel_value, 64'h0E0D0C0B);
    count_active("s3_len", STEPS);

    // Missing s_last on the fourth pixel
    send4(8'd21, 8'd22, 8'd23, 8'd24, 1'b0);
    chk("s4_err", frame_err, 1'b1);
    send4(8'd31, 8'd32, 8'd33, 8'd34, 1'b1);
    cyc1();
    chk("s4_start", frame_start, 1'b1);
    chk("s4_pixels", pixel_value, 64'h2221201F);
    count_active("s4_len", STEPS);

    // No ticks: idle stays idle, a presented frame holds indefinitely
    tick_period = 0;
    repeat (5) cyc1();
    send4(8'd50, 8'd60, 8'd70, 8'd80, 1'b1);
    repeat (12) cyc1();
    chk("s5_hold", frame_active, 1'b1);
    chk("s5_pixels", pixel_value, 64'h50463C32);
    tick_period = 2;
    wait_for(0, "s5_done_timeout");
    wait_for(1, "s5_idle_timeout");

    // Reset during presentation after five counted ticks
    tick_period = 1;
    send4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    cyc1();
    chk("s6_start", frame_start, 1'b1);
    repeat (5) cyc1();
    chk("s6_mid", frame_active, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_ready", s_ready, 1'b1);
    chk("s6_rst_active", frame_active, 1'b0);
    chk("s6_rst_done", frame_done, 1'b0);
    chk("s6_rst_err", frame_err, 1'b0);
    chk("s6_rst_pixels", pixel_value, 64'd0);
    cyc1();
    rst_n = 1'b1;
    cyc1();
    send4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    cyc1();
    chk("s6_start2", frame_start, 1'b1);
    chk("s6_pixels2", pixel_value, 64'h04030201);
    count_active("s6_len", STEPS);

    repeat (3) cyc1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
